// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding and the default operand width.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational ripple-borrow subtractor used for the trial subtraction.
// Ports:
//   a_i      : minuend (N bits)
//   b_i      : subtrahend (N bits)
//   diff_o   : a_i - b_i modulo 2^N
//   borrow_o : 1 when a_i < b_i (the subtraction borrowed out of the MSB)
module div_trial_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] brw;

  assign brw[0] = 1'b0;

  // One full-subtractor cell per bit: XOR for the difference, borrow ripples up.
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff_o[i]  = a_i[i] ^ b_i[i] ^ brw[i];
    assign brw[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw[i]);
  end

  assign borrow_o = brw[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : request; accepted in IDLE or DONE, ignored in RUN
//   A, B         : dividend / divisor, captured when start is accepted
//   Q, R         : registered quotient / remainder, stable outside completion
//   busy         : high while the WIDTH iteration steps are running
//   done         : one-cycle pulse when Q/R hold a new result
//   div_by_zero  : set with the result of a B=0 request (Q=all-ones, R=A)
//   dbg_state_o  : current controller state
// Handshake: start is a level sampled on each rising clk; it is taken only
// when the controller is IDLE or DONE, and the result is signalled by a
// single-cycle done pulse. There is no backpressure on the result.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output state_e           dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH:0]   rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend bits out, quotient bits in
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             b_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             unused_rem_msb;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign b_zero = (B == '0);

  // The kept remainder is always below the divisor, so its MSB is zero and
  // only the low WIDTH bits feed the next shift.
  assign shifted        = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign unused_rem_msb = rem_q[WIDTH];

  div_trial_sub #(.N(WIDTH + 1)) u_trial_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, divisor_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // Borrow means the divisor did not fit: restore and emit a 0 quotient bit.
  assign step_rem = borrow ? shifted : diff;
  assign step_quo = {dvd_q[WIDTH-2:0], ~borrow};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = b_zero ? DONE : RUN;
      RUN:     if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    if (start) state_d = b_zero ? DONE : RUN;
               else       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    dbg_state_o = state_q;
  end

  // Datapath next-state
  always_comb begin
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    if (accept) begin
      rem_d     = '0;
      dvd_d     = A;
      divisor_d = B;
      cnt_d     = '0;
      dbz_d     = b_zero;
      if (b_zero) begin
        q_d = '1;
        r_d = A;
      end
    end else if (state_q == RUN) begin
      rem_d = step_rem;
      dvd_d = step_quo;
      cnt_d = cnt_q + CW'(1);
      // Visible results change only on the final step.
      if (cnt_q == LAST_STEP) begin
        q_d = step_quo;
        r_d = step_rem[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule
